// File: rtl/readout_nbucket_seq.sv
// Row/column readout sequencer: scans ROW_START..ROW_END, digitises 1/2/4
// bucket phases per row, repeats NUM_FRAME frames, and runs the serializer
// LOAD_IN/ADC_DATA_VALID FSM off the internal latch-reset pulse.
module readout_nbucket_seq #(
  parameter int ROW_W        = 10,
  parameter int PH_W         = 2,
  parameter int PRIME_CYCLES = 23
) (
  input  logic              TX_CLK,
  input  logic              rst_n,
  input  logic              trigger_i,
  input  logic              abort_i,
  input  logic [1:0]        mode_i,
  input  logic [ROW_W-1:0]  ROW_START,
  input  logic [ROW_W-1:0]  ROW_END,
  input  logic [15:0]       NUM_FRAME,
  input  logic [31:0]       Tcolumn,
  input  logic [31:0]       T1,
  input  logic [31:0]       T2_1,
  input  logic [31:0]       T2_0,
  input  logic [31:0]       T3,
  input  logic [31:0]       T4,
  input  logic [31:0]       TADC,
  input  logic [31:0]       T6,
  input  logic [31:0]       T7,
  input  logic [31:0]       T8,
  input  logic [31:0]       T9,
  input  logic [31:0]       T_RO_Wait,
  output logic              re_busy,
  output logic              frame_done,
  output logic [ROW_W-2:0]  ROWADD,
  output logic              SET_ROW,
  input  logic              SET_ROW_DONE,
  output logic [PH_W-1:0]   PHASE,
  output logic              PIXLEFTBUCK_SEL,
  output logic              ODDCOL_EN,
  output logic              PRECH_COL,
  output logic              ADC_RST,
  output logic              ADC_CLK,
  output logic              RST_BAR_LTCHD,
  output logic              LOAD_IN,
  output logic              ADC_DATA_VALID,
  output logic              PIXREAD_SEL,
  output logic              ADC_BIAS_EN,
  output logic              COLL_EN,
  output logic              PIXRES
);

  localparam int PHX  = (PH_W < 2) ? 2 : PH_W;
  localparam int PC_W = (PRIME_CYCLES < 2) ? 1 : $clog2(PRIME_CYCLES);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_SETROW, S_START, S_REPEAT, S_ROWNEXT, S_WAIT} st1_t;
  typedef enum logic [1:0] {Z_IDLE, Z_MON, Z_PRIME, Z_LOAD} st2_t;

  st1_t             st1;
  st2_t             st2;
  logic             trig_q, abort_seen, m4, m2p;
  logic [ROW_W-1:0] row, rstart, rend;
  logic [15:0]      frame, nf;
  logic [PH_W-1:0]  phase, ph_last;
  logic [PHX-1:0]   phase_x;
  logic [31:0]      t, ta, lt;
  logic [PC_W-1:0]  pc;
  logic             abort_any;

  // internal (pre-register) control values
  logic busy_i, fd_i, setrow_i, arst_i, prech_i, aclk_i, rstb_i, left_i, odd_i, load_i, dv_i;

  assign phase_x   = PHX'(phase);
  assign ph_last   = m4 ? PH_W'(3) : (m2p ? PH_W'(1) : '0);
  assign abort_any = abort_seen | abort_i;

  // Row/phase/frame sequencer
  always_ff @(posedge TX_CLK) begin
    if (!rst_n) begin
      st1 <= S_IDLE; trig_q <= 1'b0; abort_seen <= 1'b0;
      m4 <= 1'b0; m2p <= 1'b0; row <= '0; rstart <= '0; rend <= '0;
      frame <= 16'd0; nf <= 16'd1; phase <= '0; t <= 32'd0; ta <= 32'd0;
    end else begin
      trig_q     <= trigger_i;
      abort_seen <= abort_any;
      case (st1)
        S_IDLE: begin
          abort_seen <= 1'b0;
          if (trig_q) begin
            // mode 2 falls back to 2 phases when PH_W cannot index 4
            m4     <= (mode_i == 2'd2) && (PH_W >= 2);
            m2p    <= (mode_i == 2'd1) || (mode_i == 2'd2);
            rstart <= ROW_START;
            rend   <= ROW_END;
            nf     <= (NUM_FRAME == 16'd0) ? 16'd1 : NUM_FRAME;
            row    <= ROW_START;
            frame  <= 16'd1;
            phase  <= '0;
            st1    <= S_SETROW;
          end
        end
        S_SETROW: if (SET_ROW_DONE) st1 <= S_START;
        S_START: begin
          t   <= 32'd1;
          ta  <= 32'd1;
          st1 <= S_REPEAT;
        end
        S_REPEAT: begin
          ta <= (ta >= TADC) ? 32'd1 : ta + 32'd1;
          if (t >= Tcolumn) begin
            if (phase < ph_last) begin
              phase <= phase + PH_ONE;
              st1   <= S_START;
            end else begin
              phase <= '0;
              st1   <= S_ROWNEXT;
            end
          end else begin
            t <= t + 32'd1;
          end
        end
        S_ROWNEXT: begin
          // >= stops after the first row when the range is inverted
          if (row >= rend || abort_any) begin
            t   <= 32'd1;
            st1 <= S_WAIT;
          end else begin
            row <= row + ROW_ONE;
            st1 <= S_SETROW;
          end
        end
        S_WAIT: begin
          if (t >= T_RO_Wait) begin
            if (frame < nf && !abort_any) begin
              frame <= frame + 16'd1;
              row   <= rstart;
              st1   <= S_SETROW;
            end else begin
              st1 <= S_IDLE;
            end
          end else begin
            t <= t + 32'd1;
          end
        end
        default: st1 <= S_IDLE;
      endcase
    end
  end

  // Decode sequencer state into raw control levels
  always_comb begin
    busy_i   = (st1 != S_IDLE);
    fd_i     = (st1 == S_WAIT) && (t >= T_RO_Wait);
    setrow_i = (st1 == S_SETROW);
    arst_i   = (st1 == S_REPEAT) && (t < T1);
    prech_i  = (st1 == S_REPEAT) && (t >= T2_1) && (t < T2_0);
    rstb_i   = !((st1 == S_REPEAT) && (t >= T3) && (t < T4));
    aclk_i   = (st1 == S_START) || ((st1 == S_REPEAT) && (ta < (TADC >> 1)));
    left_i   = busy_i && (m4  ? phase_x[1] : 1'b1);
    odd_i    = busy_i && (m2p ? phase_x[0] : 1'b1);
    load_i   = (st2 == Z_PRIME) ? pc[0] : ((st2 == Z_LOAD) && (lt < T6));
    dv_i     = (st2 == Z_LOAD) && (lt >= T8) && (lt < T9);
  end

  // Serializer: arm on latch-reset low, prime burst after release, then load window
  always_ff @(posedge TX_CLK) begin
    if (!rst_n) begin
      st2 <= Z_IDLE; pc <= '0; lt <= 32'd0;
    end else begin
      case (st2)
        Z_IDLE: if (!rstb_i) st2 <= Z_MON;
        Z_MON: if (rstb_i) begin
          pc  <= '0;
          st2 <= Z_PRIME;
        end
        Z_PRIME: begin
          if (pc == PC_W'(PRIME_CYCLES - 1)) begin
            lt  <= 32'd1;
            st2 <= Z_LOAD;
          end else begin
            pc <= pc + 1'b1;
          end
        end
        Z_LOAD: begin
          if (lt >= T7) st2 <= Z_IDLE;
          else          lt  <= lt + 32'd1;
        end
        default: st2 <= Z_IDLE;
      endcase
    end
  end

  // Output register: every pin is one cycle behind its internal level
  always_ff @(posedge TX_CLK) begin
    if (!rst_n) begin
      re_busy <= 1'b0; frame_done <= 1'b0; ROWADD <= '0; SET_ROW <= 1'b0;
      PHASE <= '0; PIXLEFTBUCK_SEL <= 1'b0; ODDCOL_EN <= 1'b0;
      PRECH_COL <= 1'b0; ADC_RST <= 1'b0; ADC_CLK <= 1'b0; RST_BAR_LTCHD <= 1'b1;
      LOAD_IN <= 1'b0; ADC_DATA_VALID <= 1'b0;
      PIXREAD_SEL <= 1'b1; ADC_BIAS_EN <= 1'b1; COLL_EN <= 1'b1; PIXRES <= 1'b0;
    end else begin
      re_busy <= busy_i; frame_done <= fd_i; ROWADD <= row[ROW_W-1:1]; SET_ROW <= setrow_i;
      PHASE <= phase; PIXLEFTBUCK_SEL <= left_i; ODDCOL_EN <= odd_i;
      PRECH_COL <= prech_i; ADC_RST <= arst_i; ADC_CLK <= aclk_i; RST_BAR_LTCHD <= rstb_i;
      LOAD_IN <= load_i; ADC_DATA_VALID <= dv_i;
      PIXREAD_SEL <= 1'b1; ADC_BIAS_EN <= 1'b1; COLL_EN <= 1'b1; PIXRES <= 1'b0;
    end
  end

endmodule

// File: tb/tb_readout_nbucket_seq.sv
// Directed bench for readout_nbucket_seq: scan, multi-phase, serializer,
// multi-frame, abort, inverted range and mid-run reset.
module tb_readout_nbucket_seq;

  logic        TX_CLK = 1'b0;
  logic        rst_n, trigger_i, abort_i, SET_ROW_DONE;
  logic [1:0]  mode_i;
  logic [9:0]  ROW_START, ROW_END;
  logic [15:0] NUM_FRAME;
  logic [31:0] Tcolumn, T1, T2_1, T2_0, T3, T4, TADC, T6, T7, T8, T9, T_RO_Wait;
  logic        re_busy, frame_done, SET_ROW, PIXLEFTBUCK_SEL, ODDCOL_EN, PRECH_COL, ADC_RST;
  logic        ADC_CLK, RST_BAR_LTCHD, LOAD_IN, ADC_DATA_VALID, PIXREAD_SEL, ADC_BIAS_EN, COLL_EN, PIXRES;
  logic [8:0]  ROWADD;
  logic [1:0]  PHASE;

  readout_nbucket_seq #(.ROW_W(10), .PH_W(2), .PRIME_CYCLES(23)) dut (
    .TX_CLK(TX_CLK), .rst_n(rst_n), .trigger_i(trigger_i), .abort_i(abort_i), .mode_i(mode_i),
    .ROW_START(ROW_START), .ROW_END(ROW_END), .NUM_FRAME(NUM_FRAME),
    .Tcolumn(Tcolumn), .T1(T1), .T2_1(T2_1), .T2_0(T2_0), .T3(T3), .T4(T4), .TADC(TADC),
    .T6(T6), .T7(T7), .T8(T8), .T9(T9), .T_RO_Wait(T_RO_Wait),
    .re_busy(re_busy), .frame_done(frame_done), .ROWADD(ROWADD), .SET_ROW(SET_ROW),
    .SET_ROW_DONE(SET_ROW_DONE), .PHASE(PHASE), .PIXLEFTBUCK_SEL(PIXLEFTBUCK_SEL),
    .ODDCOL_EN(ODDCOL_EN), .PRECH_COL(PRECH_COL), .ADC_RST(ADC_RST), .ADC_CLK(ADC_CLK),
    .RST_BAR_LTCHD(RST_BAR_LTCHD), .LOAD_IN(LOAD_IN), .ADC_DATA_VALID(ADC_DATA_VALID),
    .PIXREAD_SEL(PIXREAD_SEL), .ADC_BIAS_EN(ADC_BIAS_EN), .COLL_EN(COLL_EN), .PIXRES(PIXRES)
  );

  always #5 TX_CLK = ~TX_CLK;

  int checks = 0;
  int errors = 0;

  // mid-cycle activity counters
  int         busy_c = 0, fd_c = 0, arst_c = 0, prech_c = 0, aclk_c = 0, selbad_c = 0, nlog = 0;
  int         ph_c [4] = '{0, 0, 0, 0};
  logic [8:0] rowlog [64];
  logic       setrow_q = 1'b0;
  logic [1:0] cur_mode = 2'd0;
  logic [1:0] exp_sel;

  always_comb begin
    exp_sel = 2'b11;
    if (cur_mode == 2'd2)      exp_sel = PHASE;
    else if (cur_mode == 2'd1) exp_sel = {1'b1, PHASE[0]};
  end

  always @(negedge TX_CLK) begin
    if (rst_n) begin
      if (re_busy) busy_c <= busy_c + 1;
      if (re_busy) ph_c[PHASE] <= ph_c[PHASE] + 1;
      if (re_busy && {PIXLEFTBUCK_SEL, ODDCOL_EN} != exp_sel) selbad_c <= selbad_c + 1;
      if (frame_done) fd_c <= fd_c + 1;
      if (ADC_RST) arst_c <= arst_c + 1;
      if (PRECH_COL) prech_c <= prech_c + 1;
      if (ADC_CLK) aclk_c <= aclk_c + 1;
      if (SET_ROW && !setrow_q && nlog < 64) begin
        rowlog[nlog] <= ROWADD;
        nlog <= nlog + 1;
      end
      setrow_q <= SET_ROW;
    end
  end

  int b0, f0, n0, a0, p0, c0, s0;
  int ph0 [4];

  task automatic snap();
    b0 = busy_c; f0 = fd_c; n0 = nlog; a0 = arst_c; p0 = prech_c; c0 = aclk_c; s0 = selbad_c;
    for (int i = 0; i < 4; i++) ph0[i] = ph_c[i];
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge TX_CLK);
      #1;
    end
  endtask

  task automatic trig();
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (!re_busy && n < 20) begin step(); n++; end
    n = 0;
    while (re_busy && n < maxc) begin step(); n++; end
    chk("run_done", re_busy, 0);
    step(2);
  endtask

  task automatic chk_reset_state(input string tag);
    chk(tag, {re_busy, frame_done, ROWADD, SET_ROW, PHASE, PIXLEFTBUCK_SEL, ODDCOL_EN,
              PRECH_COL, ADC_RST, ADC_CLK, ~RST_BAR_LTCHD, LOAD_IN, ADC_DATA_VALID}, 0);
    chk({tag, "_const"}, {PIXREAD_SEL, ADC_BIAS_EN, COLL_EN, PIXRES}, 4'b1110);
  endtask

  task automatic start_run(input logic [1:0] m, input int rs, input int re, input int nfr);
    mode_i = m; cur_mode = m;
    ROW_START = 10'(rs); ROW_END = 10'(re); NUM_FRAME = 16'(nfr);
    snap();
    trig();
  endtask

  initial begin
    int n;
    logic [31:0] ld, dv, eld, edv;
    int exp_rows [6];

    rst_n = 1'b0; trigger_i = 1'b0; abort_i = 1'b0; SET_ROW_DONE = 1'b1; mode_i = 2'd0;
    ROW_START = '0; ROW_END = '0; NUM_FRAME = 16'd1;
    Tcolumn = 40; T1 = 5; T2_1 = 6; T2_0 = 8; T3 = 10; T4 = 12; TADC = 4;
    T6 = 4; T7 = 8; T8 = 5; T9 = 7; T_RO_Wait = 6;
    step(3);
    chk_reset_state("reset");
    rst_n = 1'b1;
    step(3);
    chk_reset_state("idle_after_reset");

    // 1: rows 0..3, one phase; serializer sequence on the first latch pulse
    start_run(2'd0, 0, 3, 1);
    n = 0;
    while (RST_BAR_LTCHD && n < 200) begin step(); n++; end
    n = 0;
    while (!RST_BAR_LTCHD && n < 50) begin step(); n++; end
    chk("rstb_low_cycles", n, 2);
    for (int k = 0; k < 32; k++) begin
      step();
      ld[k] = LOAD_IN;
      dv[k] = ADC_DATA_VALID;
      eld[k] = (k < 23) ? k[0] : (k < 26);
      edv[k] = (k == 27) || (k == 28);
    end
    chk("load_in_seq", ld, eld);
    chk("data_valid_seq", dv, edv);
    wait_idle(400);
    chk("t1_busy", busy_c - b0, 178);
    chk("t1_frames", fd_c - f0, 1);
    chk("t1_setrows", nlog - n0, 4);
    exp_rows = '{0, 0, 1, 1, 0, 0};
    for (int i = 0; i < 4; i++) chk("t1_rowadd", rowlog[n0 + i], exp_rows[i]);
    chk("t1_adc_rst", arst_c - a0, 16);
    chk("t1_prech", prech_c - p0, 8);
    chk("t1_adc_clk", aclk_c - c0, 44);
    chk("t1_phase0", ph_c[0] - ph0[0], 178);
    chk("t1_sel", selbad_c - s0, 0);

    // 2: four phases on one row
    start_run(2'd2, 5, 5, 1);
    wait_idle(400);
    chk("t2_busy", busy_c - b0, 172);
    chk("t2_phase0", ph_c[0] - ph0[0], 49);
    chk("t2_phase1", ph_c[1] - ph0[1], 41);
    chk("t2_phase2", ph_c[2] - ph0[2], 41);
    chk("t2_phase3", ph_c[3] - ph0[3], 41);
    chk("t2_sel", selbad_c - s0, 0);
    chk("t2_rowadd", rowlog[n0], 2);

    // 3: three frames, two rows, two phases; row reloads each frame
    start_run(2'd1, 1, 2, 3);
    wait_idle(1000);
    chk("t3_frames", fd_c - f0, 3);
    chk("t3_busy", busy_c - b0, 522);
    chk("t3_setrows", nlog - n0, 6);
    exp_rows = '{0, 1, 0, 1, 0, 1};
    for (int i = 0; i < 6; i++) chk("t3_rowadd", rowlog[n0 + i], exp_rows[i]);
    chk("t3_phase1", ph_c[1] - ph0[1], 246);
    chk("t3_sel", selbad_c - s0, 0);

    // 4: abort during row 1 of 0..3
    start_run(2'd0, 0, 3, 1);
    n = 0;
    while (nlog - n0 < 2 && n < 200) begin step(); n++; end
    step(10);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    wait_idle(400);
    chk("t4_setrows", nlog - n0, 2);
    chk("t4_busy", busy_c - b0, 92);
    chk("t4_frames", fd_c - f0, 1);

    // 5: inverted range, NUM_FRAME=0, reserved mode; abort must not linger
    start_run(2'd3, 3, 1, 0);
    wait_idle(400);
    chk("t5_setrows", nlog - n0, 1);
    chk("t5_rowadd", rowlog[n0], 1);
    chk("t5_busy", busy_c - b0, 49);
    chk("t5_frames", fd_c - f0, 1);
    chk("t5_sel", selbad_c - s0, 0);

    // 6: reset in the middle of REPEAT
    start_run(2'd2, 0, 3, 2);
    n = 0;
    while (nlog - n0 < 1 && n < 200) begin step(); n++; end
    step(12);
    chk("t6_busy_before", re_busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk_reset_state("mid_reset");
    step(5);
    chk_reset_state("mid_reset_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/readout_nbucket_seq.md
Name: readout_nbucket_seq

Overview:
Parametrised row/column readout sequencer for the CEP sensor ADC path; successor to the single-bucket 1-bit readout sequencer. It scans rows ROW_START..ROW_END and digitises 1, 2 or 4 bucket/column phases per row, selected at run time. It runs a configurable number of back-to-back frames per trigger. It sits between the host register file (timing words) and the sensor row decoder, ADC and serializer pins, and includes the independent LOAD_IN/ADC_DATA_VALID serializer FSM.

Parameters:
ROW_W, 10, row address width; ROWADD output is ROW_W-1 bits wide.
PH_W, 2, phase index width; maximum phases per row is 2^PH_W.
PRIME_CYCLES, 23, length in cycles of the serializer LOAD_IN prime toggle burst.

Ports:
TX_CLK  in  1  sole clock.
rst_n  in  1  reset; synchronous, active-low.
trigger_i  in  1  frame-start request; registered once before use.
abort_i  in  1  stop request, honoured at the next row boundary.
mode_i  in  2  phases per row: 0=1, 1=2, 2=4 (4 needs PH_W≥2), 3=reserved, treated as 1.
ROW_START, ROW_END  in  ROW_W each  inclusive scan range.
NUM_FRAME  in  16  frames per trigger; 0 means 1.
Tcolumn, T1, T2_1, T2_0, T3, T4, TADC, T6, T7, T8, T9, T_RO_Wait  in  32 each  timing words in TX_CLK cycles.
re_busy  out  1  high from trigger acceptance to return to idle.
frame_done  out  1  one-cycle pulse at the end of each frame.
ROWADD  out  ROW_W-1  row address; the LSB is dropped, ROWADD = row_i[ROW_W-1:1].
SET_ROW  out  1  row-decoder load strobe.
SET_ROW_DONE  in  1  decoder acknowledge.
PHASE  out  PH_W  current phase index.
PIXLEFTBUCK_SEL, ODDCOL_EN  out  1 each  bucket and column select.
PRECH_COL, ADC_RST, ADC_CLK, RST_BAR_LTCHD, LOAD_IN, ADC_DATA_VALID  out  1 each  ADC and serializer controls.
PIXREAD_SEL, ADC_BIAS_EN, COLL_EN  out  1 each  held constant at 1.
PIXRES  out  1  held constant at 0.

Behaviour:
- All outputs are driven from an internal signal through one output register, giving one cycle of latency.
- Reset values: every output 0, except RST_BAR_LTCHD=1, PIXREAD_SEL=ADC_BIAS_EN=COLL_EN=1.
- Reset mid-operation returns both FSMs to IDLE in the next cycle.
- FSM1 states:
  - IDLE: on registered trigger, latch mode, ROW_START/ROW_END and NUM_FRAME; set row=ROW_START, frame=1, phase=0; go to SETROW.
  - SETROW: SET_ROW=1; go to START when SET_ROW_DONE=1.
  - START: one cycle; timers t=1, ta=1; ADC_CLK=1.
  - REPEAT: t counts 1..Tcolumn; ta counts 1..TADC with wrap.
    - ADC_RST=(t<T1).
    - PRECH_COL=(T2_1≤t<T2_0).
    - RST_BAR_LTCHD=0 when T3≤t<T4, else 1.
    - ADC_CLK=(ta<TADC>>1).
    - At t=Tcolumn: if phase<nph-1, increment phase and go to START. Otherwise phase=0 and go to ROWNEXT.
  - ROWNEXT: one cycle. If row==ROW_END or abort was seen: go to WAIT. Otherwise row+1 and go to SETROW.
  - WAIT: counts 1..T_RO_Wait. At the end, pulse frame_done. Then:
    - if frame<NUM_FRAME and no abort: frame+1, row=ROW_START, go to SETROW;
    - otherwise go to IDLE.
- abort_i is sticky once seen and is cleared in IDLE.
- ROW_END<ROW_START: WAIT is entered after the first row; no wrap.
- Row increment wraps modulo 2^ROW_W.
- Phase outputs: PIXLEFTBUCK_SEL = phase[1] when nph=4, else 1. ODDCOL_EN = phase[0] when nph≥2, else 1.
- Trigger held high re-arms only from IDLE; a trigger during busy is ignored.
- FSM2 (serializer) states:
  - IDLE: go to MON when internal RST_BAR_LTCHD=0.
  - MON: wait for RST_BAR_LTCHD=1.
  - PRIME: LOAD_IN toggles each cycle for PRIME_CYCLES cycles, starting from 0.
  - LOAD: timer 1..T7; LOAD_IN=(t<T6); ADC_DATA_VALID=(T8≤t<T9); then IDLE.
- A new latch during PRIME or LOAD is not queued; the timing words must prevent it.

Test Plan:
- ROW_START=0, ROW_END=3, mode=0, Tcolumn=40, NUM_FRAME=1, SET_ROW_DONE tied 1 -> 4 rows × 1 phase; ROWADD sequence 0,0,1,1; one frame_done; re_busy falls T_RO_Wait+1 cycles after the last REPEAT.
- mode=2, one row -> PHASE sequence 0,1,2,3; {PIXLEFTBUCK_SEL,ODDCOL_EN} = 00,01,10,11; 4×(Tcolumn+1) cycles per row.
- T3=10, T4=12, PRIME_CYCLES=23, T6=4, T7=8, T8=5, T9=7 -> RST_BAR_LTCHD low 2 cycles; LOAD_IN 23 alternating cycles, then high 3 cycles; ADC_DATA_VALID high 2 cycles.
- NUM_FRAME=3 -> exactly 3 frame_done pulses, with the row reloaded to ROW_START each frame.
- abort_i pulsed mid-row 1 of 4 -> row 1 completes, then WAIT, then IDLE; no row 2.
- rst_n=0 during REPEAT -> next cycle both FSMs are in IDLE; all outputs at their reset values one cycle later.
